// File: rtl/rotor_arbiter.sv
// rotor_arbiter: three-requester round-robin arbiter with a rotating one-hot
// priority pointer, selectable rotation direction, bounded ownership time and
// a mandatory one-cycle gap between consecutive grants.
module rotor_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic [2:0] done,
  input  logic       dir,
  output logic [2:0] grant,
  output logic       busy,
  output logic       timeout,
  output logic [2:0] ptr
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

  state_t     state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic [2:0] ptr_q, ptr_d;
  logic       dir_lat_q, dir_lat_d;

  logic [2:0] cand1, cand2, pick;
  logic       owner_done, owner_req, at_limit;

  function automatic logic [2:0] rotl(input logic [2:0] v);
    return {v[1:0], v[2]};
  endfunction

  function automatic logic [2:0] rotr(input logic [2:0] v);
    return {v[0], v[2:1]};
  endfunction

  // Priority search starting at the pointer, walking in the live dir.
  always_comb begin
    cand1 = dir ? rotr(ptr_q) : rotl(ptr_q);
    cand2 = dir ? rotr(rotr(ptr_q)) : rotl(rotl(ptr_q));
    pick  = '0;
    if (|(req & ptr_q))
      pick = ptr_q;
    else if (|(req & cand1))
      pick = cand1;
    else if (|(req & cand2))
      pick = cand2;
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    ptr_d      = ptr_q;
    dir_lat_d  = dir_lat_q;

    owner_done = |(done & grant_q);
    owner_req  = |(req & grant_q);
    at_limit   = (hold_cnt_q == HOLD_LAST);

    case (state_q)
      GRANT: begin
        if (owner_done || !owner_req || at_limit) begin
          state_d    = GAP;
          grant_d    = '0;
          busy_d     = 1'b0;
          hold_cnt_d = '0;
          ptr_d      = dir_lat_q ? rotr(grant_q) : rotl(grant_q);
          // Timeout flags only a release forced purely by the hold limit.
          timeout_d  = at_limit && !owner_done && owner_req;
        end else begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end
      GAP: begin
        state_d    = IDLE;
        grant_d    = '0;
        busy_d     = 1'b0;
        hold_cnt_d = '0;
      end
      // IDLE and any unused encoding behave identically.
      default: begin
        state_d    = IDLE;
        grant_d    = '0;
        busy_d     = 1'b0;
        hold_cnt_d = '0;
        if (|req) begin
          state_d   = GRANT;
          grant_d   = pick;
          busy_d    = 1'b1;
          dir_lat_d = dir;
        end
      end
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      hold_cnt_q <= '0;
      ptr_q      <= 3'b001;
      dir_lat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      hold_cnt_q <= hold_cnt_d;
      ptr_q      <= ptr_d;
      dir_lat_q  <= dir_lat_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;
  assign ptr     = ptr_q;

endmodule

// File: tb/tb_rotor_arbiter.sv
// Testbench for rotor_arbiter: directed scenarios plus randomized traffic,
// checked through an expectation queue fed by an index-based reference model.
module tb_rotor_arbiter;

  localparam int HOLD = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] req   = '0;
  logic [2:0] done  = '0;
  logic       dir   = 1'b0;
  logic [2:0] grant;
  logic       busy;
  logic       timeout;
  logic [2:0] ptr;

  rotor_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .dir     (dir),
    .grant   (grant),
    .busy    (busy),
    .timeout (timeout),
    .ptr     (ptr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] grant;
    logic       busy;
    logic       timeout;
    logic [2:0] ptr;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  event sample_ev;

  // Reference model: owner index (-1 = none), cycles already held,
  // cycles to wait before arbitration, pointer index, latched direction.
  int m_owner  = -1;
  int m_held   = 0;
  int m_wait   = 0;
  int m_ptr    = 0;
  bit m_dirlat = 1'b0;
  bit m_tmo    = 1'b0;

  task automatic model_step(input logic [2:0] r, input logic [2:0] d,
                            input logic dr, input logic rs);
    int  step;
    int  idx;
    bit  found;
    bit  rel_done;
    bit  rel_drop;
    bit  rel_lim;
    if (rs) begin
      m_owner = -1; m_held = 0; m_wait = 0; m_ptr = 0; m_dirlat = 1'b0; m_tmo = 1'b0;
    end else begin
      m_tmo = 1'b0;
      if (m_owner >= 0) begin
        rel_done = d[m_owner];
        rel_drop = !r[m_owner];
        rel_lim  = (m_held == HOLD - 1);
        if (rel_done || rel_drop || rel_lim) begin
          m_tmo   = rel_lim && !rel_done && !rel_drop;
          m_ptr   = m_dirlat ? (m_owner + 2) % 3 : (m_owner + 1) % 3;
          m_owner = -1;
          m_held  = 0;
          m_wait  = 1;
        end else begin
          m_held = m_held + 1;
        end
      end else if (m_wait > 0) begin
        m_wait = m_wait - 1;
      end else if (r != 3'b000) begin
        step  = dr ? 2 : 1;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
          idx = (m_ptr + k * step) % 3;
          if (!found && r[idx]) begin
            found    = 1'b1;
            m_owner  = idx;
            m_held   = 0;
            m_dirlat = dr;
          end
        end
      end
    end
  endtask

  task automatic push_expected();
    exp_t e;
    logic [2:0] g;
    logic [2:0] p;
    g = '0;
    p = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    p[m_ptr]  = 1'b1;
    e.grant   = g;
    e.busy    = (m_owner >= 0);
    e.timeout = m_tmo;
    e.ptr     = p;
    q.push_back(e);
  endtask

  task automatic cycle(input logic [2:0] r, input logic [2:0] d,
                       input logic dr, input logic rs);
    @(negedge clock);
    req   = r;
    done  = d;
    dir   = dr;
    reset = rs;
    model_step(r, d, dr, rs);
    push_expected();
  endtask

  // Drive req/dir and pulse done for the owner in its first grant cycle.
  task automatic run_auto(input logic [2:0] r, input logic dr, input int n);
    logic [2:0] d;
    for (int i = 0; i < n; i++) begin
      d = '0;
      if (m_owner >= 0 && m_held == 0) d[m_owner] = 1'b1;
      cycle(r, d, dr, 1'b0);
    end
  endtask

  // Assert reset in the high phase, away from both edges, and check at once.
  task automatic async_reset();
    @(posedge clock);
    #3;
    reset = 1'b1;
    model_step(req, done, dir, 1'b1);
    push_expected();
    ->sample_ev;
  endtask

  task automatic cmp3(input string name, input logic [2:0] got, input logic [2:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, got, want);
    end
  endtask

  task automatic check_one();
    exp_t e;
    if (q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL queue at %0t: got empty want entry", $time);
    end else begin
      e = q.pop_front();
      cmp3("grant", grant, e.grant);
      cmp3("busy", {2'b00, busy}, {2'b00, e.busy});
      cmp3("timeout", {2'b00, timeout}, {2'b00, e.timeout});
      cmp3("ptr", ptr, e.ptr);
    end
  endtask

  // Monitor: sample after every active edge and after each async reset.
  initial begin
    @(negedge clock);
    forever begin
      @(posedge clock or sample_ev);
      #1;
      check_one();
    end
  end

  initial begin
    logic [2:0] r;
    logic [2:0] d;
    logic       dr;
    logic       rs;

    // Reset held for a few cycles.
    repeat (3) cycle(3'b000, 3'b000, 1'b0, 1'b1);

    // Clockwise rotation with done pulses.
    run_auto(3'b111, 1'b0, 12);
    repeat (2) cycle(3'b000, 3'b000, 1'b0, 1'b1);

    // Counter-clockwise rotation with done pulses.
    run_auto(3'b111, 1'b1, 12);
    repeat (2) cycle(3'b000, 3'b000, 1'b0, 1'b1);

    // Hold limit: single requester, no done.
    repeat (10) cycle(3'b010, 3'b000, 1'b0, 1'b0);
    repeat (2) cycle(3'b000, 3'b000, 1'b0, 1'b1);

    // Owner drops its request.
    repeat (2) cycle(3'b100, 3'b000, 1'b0, 1'b0);
    repeat (3) cycle(3'b000, 3'b000, 1'b0, 1'b0);
    repeat (2) cycle(3'b000, 3'b000, 1'b0, 1'b1);

    // Asynchronous reset mid-grant, then re-arbitration.
    repeat (2) cycle(3'b010, 3'b000, 1'b0, 1'b0);
    async_reset();
    cycle(3'b010, 3'b000, 1'b0, 1'b1);
    repeat (3) cycle(3'b011, 3'b000, 1'b0, 1'b0);
    repeat (2) cycle(3'b000, 3'b000, 1'b0, 1'b1);

    // Non-owner activity and dir changes during a grant.
    cycle(3'b001, 3'b000, 1'b0, 1'b0);
    cycle(3'b111, 3'b110, 1'b1, 1'b0);
    cycle(3'b011, 3'b000, 1'b1, 1'b0);
    cycle(3'b101, 3'b001, 1'b1, 1'b0);
    repeat (3) cycle(3'b000, 3'b000, 1'b1, 1'b0);

    // Randomized traffic with sticky requests and occasional resets.
    r  = 3'b000;
    dr = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) dr = ~dr;
      d  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      rs = ($urandom_range(0, 99) == 0);
      if (i % 300 == 150) async_reset();
      cycle(r, d, dr, rs);
    end
    repeat (2) cycle(3'b000, 3'b000, 1'b0, 1'b0);

    @(posedge clock);
    #3;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain at %0t: got %0d want 0", $time, q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
